// File: rtl/cmd_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmd_dispatch_pkg                                             |
// | Description : Shared constants and types for the command dispatcher:      |
// |               local-window command offsets, queue entry width and the      |
// |               bus issue state encoding.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cmd_dispatch_pkg;

  // Offsets within the 16-address local control window
  localparam logic [3:0] LOC_CTRL  = 4'h0;  // write ctrl_out
  localparam logic [3:0] LOC_CLR   = 4'h1;  // clear overflow / drop_cnt
  localparam logic [3:0] LOC_FLUSH = 4'hF;  // discard all queued commands

  // Queue entry layout: {addr[7:0], data[15:0]}
  localparam int CMD_W = 24;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmd_fifo                                                     |
// | Description : Synchronous FIFO with push, pop and flush. Read data is the  |
// |               current head (show-ahead). Push into a full FIFO and pop of  |
// |               an empty FIFO are ignored. Flush clears pointers and level   |
// |               and takes priority over push/pop bookkeeping.                |
// | Ports       : i_clk, rst_n (async, active-low), push_i, pop_i, flush_i,    |
// |               wdata_i, rdata_o, full_o, empty_o, level_o                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Fullness is judged on the level before the edge, so a same-cycle pop
  // never makes room for a push.
  assign w_push_ok = push_i && !full_o;
  assign w_pop_ok  = pop_i && !empty_o;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmd_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmd_dispatch                                                 |
// | Description : Consumes completed UART commands. Addresses in the local     |
// |               16-address window act on control/status state; all others   |
// |               are queued and issued to the register bus via valid/ready.   |
// | Ports       : i_clk, rst_n (async, active-low)                             |
// |               cmd_en/cmd_addr/cmd_data  - command strobe and payload       |
// |               bus_valid/bus_addr/bus_data/bus_ready - register bus write   |
// |               ctrl_out   - local control register                          |
// |               fifo_level - queue occupancy                                 |
// |               overflow, drop_cnt - sticky drop flag, saturating count      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter logic [7:0] LOCAL_BASE = 8'hF0
) (
  input  logic                     i_clk,
  input  logic                     rst_n,
  input  logic                     cmd_en,
  input  logic [7:0]               cmd_addr,
  input  logic [16:0]              cmd_data,
  output logic                     bus_valid,
  output logic [7:0]               bus_addr,
  output logic [15:0]              bus_data,
  input  logic                     bus_ready,
  output logic [15:0]              ctrl_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  issue_state_e     state_q;
  logic             bus_valid_q;
  logic [7:0]       bus_addr_q;
  logic [15:0]      bus_data_q;
  logic [15:0]      ctrl_q;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             w_local, w_loc_cmd, w_push, w_pop, w_flush, w_clr, w_drop;
  logic             w_full, w_empty;
  logic [CMD_W-1:0] w_rdata;
  logic             w_unused_ok;

  // Bit 16 of the command data carries no meaning here.
  assign w_unused_ok = cmd_data[16];

  assign w_local   = (cmd_addr[7:4] == LOCAL_BASE[7:4]);
  assign w_loc_cmd = cmd_en && w_local;
  assign w_push    = cmd_en && !w_local;
  assign w_flush   = w_loc_cmd && (cmd_addr[3:0] == LOC_FLUSH);
  assign w_clr     = w_loc_cmd && (cmd_addr[3:0] == LOC_CLR);
  assign w_drop    = w_push && w_full;
  assign w_pop     = (state_q == ST_IDLE) && !w_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .wdata_i ({cmd_addr, cmd_data[15:0]}),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (fifo_level)
  );

  // Local control register
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (w_loc_cmd && (cmd_addr[3:0] == LOC_CTRL)) begin
      ctrl_q <= cmd_data[15:0];
    end
  end

  // Drop status; clear and drop are mutually exclusive (local vs. queued).
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (w_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (w_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Issue FSM: the pop loads the head straight into the bus registers, so a
  // flush on the same edge cannot cancel the transfer being issued.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!w_empty) begin
            bus_addr_q  <= w_rdata[23:16];
            bus_data_q  <= w_rdata[15:0];
            bus_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          bus_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_data  = bus_data_q;
  assign ctrl_out  = ctrl_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cmd_dispatch                                              |
// | Description : Self-checking bench for cmd_dispatch. A queue-based model    |
// |               tracks queued commands, the transfer on the bus, the local   |
// |               control register and drop status; directed scenarios and a  |
// |               randomized run compare the DUT against it.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cmd_dispatch;

  localparam int DEPTH = 4;

  logic        i_clk     = 1'b0;
  logic        rst_n     = 1'b1;
  logic        cmd_en    = 1'b0;
  logic [7:0]  cmd_addr  = '0;
  logic [16:0] cmd_data  = '0;
  logic        bus_ready = 1'b0;
  logic        bus_valid;
  logic [7:0]  bus_addr;
  logic [15:0] bus_data;
  logic [15:0] ctrl_out;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_dispatch #(.DEPTH(DEPTH), .LOCAL_BASE(8'hF0)) dut (
    .i_clk      (i_clk),
    .rst_n      (rst_n),
    .cmd_en     (cmd_en),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_ready  (bus_ready),
    .ctrl_out   (ctrl_out),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  logic [23:0] mq[$];     // commands waiting in the queue
  bit          m_busy;    // a transfer is presented on the bus
  logic [23:0] m_cur;     // {addr,data} of that transfer
  logic [15:0] m_ctrl;
  bit          m_ovf;
  int          m_drop;
  logic [23:0] obs[$];    // completed bus transfers, in order

  function automatic void model_reset();
    mq.delete();
    m_busy = 0; m_cur = '0; m_ctrl = '0; m_ovf = 0; m_drop = 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented at it.
  function automatic void model_edge();
    bit was_full;
    bit is_loc;
    was_full = (mq.size() == DEPTH);
    is_loc   = cmd_en && (cmd_addr[7:4] == 4'hF);
    if (m_busy) begin
      if (bus_ready) m_busy = 0;
    end else if (mq.size() != 0) begin
      m_cur  = mq.pop_front();
      m_busy = 1;
    end
    if (is_loc) begin
      if (cmd_addr[3:0] == 4'h0)      m_ctrl = cmd_data[15:0];
      else if (cmd_addr[3:0] == 4'h1) begin m_ovf = 0; m_drop = 0; end
      else if (cmd_addr[3:0] == 4'hF) mq.delete();
    end else if (cmd_en) begin
      if (was_full) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back({cmd_addr, cmd_data[15:0]});
      end
    end
  endfunction

  // One clock: present inputs at a falling edge, advance model at the rising
  // edge, return at the next falling edge with outputs settled.
  task automatic step(input bit en, input logic [7:0] a, input logic [15:0] d);
    cmd_en   = en;
    cmd_addr = a;
    cmd_data = {1'($urandom_range(0, 1)), d};
    if (bus_valid && bus_ready) obs.push_back({bus_addr, bus_data});
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    cmd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    rst_n = 1'b1;
    model_reset();
    obs.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    n_tests++; if (bus_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_bus_valid: got %0b want 0", bus_valid); end
    n_tests++; if (bus_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_bus_addr: got %h want 00", bus_addr); end
    n_tests++; if (bus_data !== 16'h0)  begin n_fail++; $display("FAIL reset_bus_data: got %h want 0000", bus_data); end
    n_tests++; if (ctrl_out !== 16'h0)  begin n_fail++; $display("FAIL reset_ctrl_out: got %h want 0000", ctrl_out); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
    n_tests++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    n_tests++; if (drop_cnt !== 8'd0)   begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    bus_ready = 1'b1;
    step(1, 8'h12, 16'hBEEF);
    n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", bus_valid); end
    step(0, 8'h00, 16'h0);
    n_tests++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", bus_valid); end
    n_tests++; if ({bus_addr, bus_data} !== 24'h12BEEF) begin n_fail++; $display("FAIL basic_payload: got %h want 12beef", {bus_addr, bus_data}); end
    step(0, 8'h00, 16'h0);
    n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %0b want 0", bus_valid); end
  endtask

  task automatic test_local();
    step(1, 8'hF0, 16'h00A5);
    n_tests++; if (ctrl_out !== 16'h00A5) begin n_fail++; $display("FAIL local_ctrl: got %h want 00a5", ctrl_out); end
    n_tests++; if (bus_valid !== 1'b0)    begin n_fail++; $display("FAIL local_no_bus: got %0b want 0", bus_valid); end
    n_tests++; if (fifo_level !== 3'd0)   begin n_fail++; $display("FAIL local_no_queue: got %0d want 0", fifo_level); end
    step(1, 8'hF5, 16'h1234);  // unused offset: no effect
    n_tests++; if (ctrl_out !== 16'h00A5 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL local_ignored: ctrl %h level %0d want 00a5 0", ctrl_out, fifo_level); end
  endtask

  task automatic test_overflow();
    logic [23:0] sent[$];
    logic [15:0] d;
    bus_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      sent.push_back({8'(8'h20 + i), d});
      step(1, 8'(8'h20 + i), d);
    end
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    n_tests++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    n_tests++; if (drop_cnt !== 8'd1)   begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
    obs.delete();
    bus_ready = 1'b1;
    repeat (12) step(0, 8'h00, 16'h0);
    n_tests++; if (obs.size() != 5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      n_tests++; if (obs[i] !== sent[i]) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h want %h", i, obs[i], sent[i]); end
    end
    step(1, 8'hF1, 16'h0);
    n_tests++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL ovf_clear: ovf %0b cnt %0d want 0 0", overflow, drop_cnt); end
  endtask

  task automatic test_flush();
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 16'(16'hC000 + i));
    step(1, 8'hFF, 16'h0);
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", fifo_level); end
    n_tests++; if (bus_valid !== 1'b1 || {bus_addr, bus_data} !== 24'h40C000) begin
      n_fail++; $display("FAIL flush_held: valid %0b payload %h want 1 40c000", bus_valid, {bus_addr, bus_data}); end
    obs.delete();
    bus_ready = 1'b1;
    repeat (8) step(0, 8'h00, 16'h0);
    n_tests++; if (obs.size() != 1 || obs[0] !== 24'h40C000) begin
      n_fail++; $display("FAIL flush_issue: got %0d transfers want 1 (40c000)", obs.size()); end
  endtask

  task automatic test_async_reset();
    bus_ready = 1'b0;
    step(1, 8'hF0, 16'hABCD);
    step(1, 8'h33, 16'h1234);
    step(0, 8'h00, 16'h0);
    n_tests++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %0b want 1", bus_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({bus_valid, bus_addr, bus_data} !== 25'd0) begin
      n_fail++; $display("FAIL arst_bus: got %h want 0", {bus_valid, bus_addr, bus_data}); end
    n_tests++; if (ctrl_out !== 16'h0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL arst_state: ctrl %h level %0d want 0 0", ctrl_out, fifo_level); end
    #1 rst_n = 1'b1;
    @(negedge i_clk);
    model_reset();
    obs.delete();
    bus_ready = 1'b1;
    step(1, 8'h55, 16'h7777);
    step(0, 8'h00, 16'h0);
    n_tests++; if (bus_valid !== 1'b1 || {bus_addr, bus_data} !== 24'h557777) begin
      n_fail++; $display("FAIL arst_after: valid %0b payload %h want 1 557777", bus_valid, {bus_addr, bus_data}); end
  endtask

  task automatic test_saturation();
    bus_ready = 1'b0;
    for (int i = 0; i < 306; i++) step(1, 8'(8'h60 + (i % 16)), 16'(i));
    n_tests++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
    n_tests++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
      n_fail++; $display("FAIL sat_state: ovf %0b level %0d want 1 4", overflow, fifo_level); end
    step(1, 8'hF1, 16'h0);
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clear: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_wrap();
    logic [23:0] sent[$];
    logic [15:0] d;
    int k;
    do_reset();
    k = 0;
    for (int i = 0; i < 45; i++) begin
      bus_ready = i[0];
      if (i % 3 == 0 && k < 10) begin
        d = 16'($urandom);
        sent.push_back({8'(8'h80 + k), d});
        step(1, 8'(8'h80 + k), d);
        k++;
      end else begin
        step(0, 8'h00, 16'h0);
      end
      n_tests++; if (fifo_level !== 3'(mq.size())) begin
        n_fail++; $display("FAIL wrap_level: got %0d want %0d", fifo_level, mq.size()); end
    end
    n_tests++; if (obs.size() != 10 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_count: got %0d transfers drops %0d want 10 0", obs.size(), drop_cnt); end
    for (int i = 0; i < 10 && i < obs.size(); i++) begin
      n_tests++; if (obs[i] !== sent[i]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", i, obs[i], sent[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    int r;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      bus_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0)      a = 8'hF0;
      else if (r == 1) a = 8'hF1;
      else if (r == 2) a = {4'hF, 4'($urandom)};
      else             a = 8'($urandom_range(0, 8'hEF));
      step(1'($urandom_range(0, 1)), a, 16'($urandom));
      n_tests++; if (bus_valid !== m_busy) begin
        n_fail++; $display("FAIL rand_valid@%0d: got %0b want %0b", i, bus_valid, m_busy); end
      if (m_busy) begin
        n_tests++; if ({bus_addr, bus_data} !== m_cur) begin
          n_fail++; $display("FAIL rand_payload@%0d: got %h want %h", i, {bus_addr, bus_data}, m_cur); end
      end
      n_tests++; if (fifo_level !== 3'(mq.size())) begin
        n_fail++; $display("FAIL rand_level@%0d: got %0d want %0d", i, fifo_level, mq.size()); end
      n_tests++; if (ctrl_out !== m_ctrl) begin
        n_fail++; $display("FAIL rand_ctrl@%0d: got %h want %h", i, ctrl_out, m_ctrl); end
      n_tests++; if (overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
        n_fail++; $display("FAIL rand_status@%0d: got %0b/%0d want %0b/%0d", i, overflow, drop_cnt, m_ovf, m_drop); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_local();
    test_overflow();
    test_flush();
    test_async_reset();
    test_saturation();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_dispatch.md
# cmd_dispatch

Downstream consumer of the UART command receiver. Takes each completed command (`cmd_en` pulse with 8-bit address and 16-bit data) and handles it in one of two ways:
- Addresses `0xF0`–`0xFF` are executed locally as control/status commands.
- All other addresses are queued in a small FIFO and issued to the internal register bus over a valid/ready handshake.

This lets the UART side run ahead of a stalled bus without losing commands, up to the FIFO depth.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `LOCAL_BASE`, 8'hF0, first address of the 16-address local window (low nibble must be 0).

Ports:
- `i_clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cmd_en`  in  1  one-cycle strobe: command valid.
- `cmd_addr`  in  8  command address.
- `cmd_data`  in  17  command data; bits [15:0] used, bit 16 ignored.
- `bus_valid`  out  1  bus write request.
- `bus_addr`  out  8  bus write address.
- `bus_data`  out  16  bus write data.
- `bus_ready`  in  1  target accepts the write when high together with `bus_valid`.
- `ctrl_out`  out  16  local control register.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: at least one command was dropped.
- `drop_cnt`  out  8  dropped-command count; saturates at 255.

## Operation
- **Reset values:** all outputs are 0. This includes `bus_valid`, `bus_addr`, `bus_data`, `ctrl_out`, `fifo_level`, `overflow` and `drop_cnt`. FIFO pointers reset to 0. The issue FSM resets to IDLE.
- **Local decode:** `cmd_addr[7:4] == LOCAL_BASE[7:4]` selects the local window. Local commands never enter the FIFO.
  - `+0`: `ctrl_out <= cmd_data[15:0]`.
  - `+1`: clear `overflow` and `drop_cnt`.
  - `+F`: flush the FIFO (pointers and level to 0). An in-flight bus transfer is unaffected.
  - Other local offsets: ignored; no side effects.
- **Queue path:** a non-local `cmd_en` pushes `{addr, data[15:0]}`.
  - If `fifo_level == DEPTH` (value before the edge), the command is dropped: `overflow <= 1` and `drop_cnt` increments, saturating at 255.
  - A pop in the same cycle does not make room for a push into a full FIFO; the push is still dropped.
- **Issue FSM:**
  - **IDLE:** if the FIFO is non-empty, pop the head into `bus_addr`/`bus_data`, set `bus_valid <= 1`, go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE:** hold `bus_valid`, `bus_addr` and `bus_data` stable until `bus_valid && bus_ready`. On that edge, `bus_valid <= 0` and return to IDLE.
- **Level and pointers:**
  - `fifo_level` updates on every accepted push and every pop. A simultaneous push and pop leaves the level unchanged.
  - Read and write pointers wrap modulo DEPTH.
- **Simultaneous events:**
  - Flush and pop in the same cycle: flush wins. Level goes to 0; the popped entry is still issued, since the pop already loaded it into the output registers.
  - Flush is itself a local command, so it can never coincide with a push.

## Timing
- A non-local `cmd_en` at edge N writes the FIFO. When the FSM is IDLE and the FIFO was empty, `bus_valid` rises after edge N+1 (2-cycle latency).
- Throughput: at most one bus transfer every 2 cycles (the ISSUE→IDLE→ISSUE round trip).
- A local register write is visible on `ctrl_out` the cycle after the `cmd_en` edge.
- Status clear: `overflow`/`drop_cnt` clear on the edge of the `+1` command.
- Reset is asynchronous: asserting `rst_n` low mid-transfer drops `bus_valid` immediately, without waiting for `i_clk`. Queued commands are lost.

## Structure
- **Shared package:** local offset constants (`LOC_CTRL=0`, `LOC_CLR=1`, `LOC_FLUSH=4'hF`) and the FSM state encoding (IDLE, ISSUE).
- **Sub-module `cmd_fifo`:** a synchronous FIFO with push/pop/flush, full, empty and level outputs, parameterised by DEPTH and width (24).
- **Top level:** `cmd_dispatch` contains the local decode, the status counters and the issue FSM.

## Test plan
- **Basic issue:** `cmd_en` with addr `0x12`, data `0xBEEF`; `bus_ready` held at 1 → `bus_valid` high for exactly 1 cycle, starting 2 cycles after the strobe, carrying `0x12`/`0xBEEF`.
- **Local write:** addr `0xF0`, data `0x00A5` → `ctrl_out == 0x00A5` on the next cycle. `bus_valid` stays 0 and `fifo_level` stays 0.
- **Overflow:** `bus_ready = 0`; send 6 non-local commands (DEPTH=4) →
  - 1 command in flight plus 4 queued (`fifo_level == 4`);
  - `overflow == 1`, `drop_cnt == 1`.
  - Then assert `bus_ready` → the 5 commands issue in order.
  - Then send `0xF1` → `overflow == 0`, `drop_cnt == 0`.
- **Flush:** `bus_ready = 0`; queue 3 commands, then send `0xFF` →
  - `fifo_level == 0`;
  - the held transfer completes once `bus_ready` rises, and nothing further issues.
- **Async reset mid-transfer:** in ISSUE with `bus_ready = 0`, pulse `rst_n` low between clock edges → all outputs go to 0 immediately. After release, the next command issues normally.
- **Saturation and pointer wrap:**
  - Force 300 drops → `drop_cnt == 255`.
  - Stream 10 commands with `bus_ready` toggling 1/0 → the pointers wrap, and the order and data on the bus are preserved.
